// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: step timer, debounced direction keys and head/tail
// position generator for a grid snake game. Each legal step produces a
// step_req/step_ack handshake towards the drawing logic.
// Optional feature: define SNAKE_WRAP_EN so the snake wraps at the screen
// edges instead of dying on a wall hit.
module snake_step_ctrl #(
    parameter logic [19:0] TICK    = 20'd1000000,
    parameter logic [15:0] DB_CYC  = 16'd50000,
    parameter int          XDIM    = 10,
    parameter int          YDIM    = 10,
    parameter int          XSCREEN = 160,
    parameter int          YSCREEN = 120,
    parameter logic [7:0]  X0      = 8'd39,
    parameter logic [6:0]  Y0      = 7'd59
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [3:0] KEY,
    input  logic       start,
    input  logic       step_ack,
    output logic       step_req,
    output logic [7:0] head_x,
    output logic [6:0] head_y,
    output logic [7:0] prev_x,
    output logic [6:0] prev_y,
    output logic [1:0] dir,
    output logic       dead
);

    typedef enum logic [1:0] {IDLE, RUN, REQ, DEAD} state_t;

    state_t      state, state_nxt;
    logic [19:0] tick_cnt;
    logic [3:0]  key_s1, key_s2;
    logic [15:0] db_cnt [4];
    logic [3:0]  pressed, pressed_d, rise;
    logic        key_hit;
    logic [1:0]  key_dir;
    logic [1:0]  pend_dir, q_dir, nd;
    logic        q_vld;
    logic        terminal;
    logic [8:0]  nx;
    logic [7:0]  ny;
    logic        legal, step_ok;
    logic [7:0]  tx;
    logic [6:0]  ty;

    // Two-stage synchronizer; resets to the released level so no phantom press follows reset
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
        end
    end

    // Per-key debounce: DB_CYC consecutive low samples make a press, one high sample releases
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            for (int i = 0; i < 4; i++) db_cnt[i] <= 16'd0;
            pressed   <= 4'd0;
            pressed_d <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i]) begin
                    db_cnt[i]  <= 16'd0;
                    pressed[i] <= 1'b0;
                end else if (!pressed[i]) begin
                    if (db_cnt[i] == DB_CYC - 16'd1) pressed[i] <= 1'b1;
                    else                            db_cnt[i]  <= db_cnt[i] + 16'd1;
                end
            end
            pressed_d <= pressed;
        end
    end

    assign rise     = pressed & ~pressed_d;
    assign key_hit  = |rise;
    assign terminal = (state == RUN) && (tick_cnt == TICK - 20'd1);
    assign nd       = ((pend_dir ^ dir) == 2'b11) ? dir : pend_dir;

    // Simultaneous presses resolve as right > down > up > left
    always_comb begin
        key_dir = 2'b00;
        if      (rise[0]) key_dir = 2'b00;
        else if (rise[1]) key_dir = 2'b01;
        else if (rise[2]) key_dir = 2'b10;
        else if (rise[3]) key_dir = 2'b11;
    end

    // Candidate head one bit wider than the ports so an underflow reads as out of range
    always_comb begin
        nx = {1'b0, head_x};
        ny = {1'b0, head_y};
        case (nd)
            2'b00:   nx = {1'b0, head_x} + 9'(XDIM);
            2'b11:   nx = {1'b0, head_x} - 9'(XDIM);
            2'b01:   ny = {1'b0, head_y} + 8'(YDIM);
            default: ny = {1'b0, head_y} - 8'(YDIM);
        endcase
        legal = !nx[8] && !ny[7] && (nx <= 9'(XSCREEN - XDIM)) && (ny <= 8'(YSCREEN - YDIM));
        tx = nx[7:0];
        ty = ny[6:0];
`ifdef SNAKE_WRAP_EN
        if (!legal) begin
            case (nd)
                2'b00:   tx = 8'd0;
                2'b11:   tx = 8'(XSCREEN - XDIM);
                2'b01:   ty = 7'd0;
                default: ty = 7'(YSCREEN - YDIM);
            endcase
        end
        step_ok = 1'b1;
`else
        step_ok = legal;
`endif
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; DEAD is only left through reset
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (terminal) state_nxt = step_ok ? REQ : DEAD;
            REQ:     if (step_ack) state_nxt = RUN;
            default: state_nxt = DEAD;
        endcase
    end

    // Output decode from state
    always_comb begin
        step_req = (state == REQ);
`ifdef SNAKE_WRAP_EN
        dead = 1'b0;
`else
        dead = (state == DEAD);
`endif
    end

    // Step timer: held at 0 in IDLE, frozen while a step waits for acknowledge
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn)           tick_cnt <= 20'd0;
        else if (state == IDLE) tick_cnt <= 20'd0;
        else if (state == RUN)  tick_cnt <= terminal ? 20'd0 : tick_cnt + 20'd1;
    end

    // Position and direction; a second press queued behind an unapplied turn is kept for the next step
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            head_x   <= X0;
            head_y   <= Y0;
            prev_x   <= X0;
            prev_y   <= Y0;
            dir      <= 2'b00;
            pend_dir <= 2'b00;
            q_dir    <= 2'b00;
            q_vld    <= 1'b0;
        end else if (terminal) begin
            dir   <= nd;
            q_vld <= 1'b0;
            if (step_ok) begin
                prev_x <= head_x;
                prev_y <= head_y;
                head_x <= tx;
                head_y <= ty;
            end
            if (q_vld)        pend_dir <= q_dir;
            else if (key_hit) pend_dir <= key_dir;
            else              pend_dir <= nd;
        end else if (key_hit && state != DEAD) begin
            if (pend_dir == dir) begin
                pend_dir <= key_dir;
            end else begin
                q_dir <= key_dir;
                q_vld <= 1'b1;
            end
        end
    end

endmodule

// File: doc/snake_step_ctrl.md
SNAKE_STEP_CTRL -- requirements
Module: snake_step_ctrl

Interface
REQ-001 SHALL have parameter TICK, default 20'd1000000, meaning clock cycles per snake step (use 4 in simulation).
REQ-002 SHALL have parameter DB_CYC, default 16'd50000, meaning consecutive low samples needed to accept a key press.
REQ-003 SHALL have parameters XDIM=10, YDIM=10, XSCREEN=160, YSCREEN=120, X0=8'd39, Y0=7'd59, meaning cell size, screen size and start position.
REQ-004 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-005 Resetn  input  1  reset, synchronous, active-low.
REQ-006 KEY  input  4  raw pushbuttons, active-low; [0]=right, [1]=down, [2]=up, [3]=left.
REQ-007 start  input  1  level; starts motion when high in IDLE.
REQ-008 step_ack  input  1  downstream draw FSM has consumed the current step.
REQ-009 step_req  output  1  new step valid; prev_*/head_* are stable while high.
REQ-010 head_x / head_y  output  8 / 7  top-left corner of the new head cell.
REQ-011 prev_x / prev_y  output  8 / 7  top-left corner of the cell to erase.
REQ-012 dir  output  2  applied direction: 00 right, 01 down, 10 up, 11 left.
REQ-013 dead  output  1  wall collision occurred; sticky until reset.

Function
REQ-014 SHALL pass each KEY bit through a 2-FF synchronizer, then a per-key debounce counter; a key is pressed after DB_CYC consecutive synchronized-low cycles and released on the first high sample.
REQ-015 SHALL latch a pending direction on a debounced press rising edge, with priority right > down > up > left when several keys rise in the same cycle.
REQ-016 SHALL ignore a pending direction that is the exact reverse of the last applied dir, checked against the applied dir and not the pending one, so two quick presses cannot reverse the snake.
REQ-017 SHALL implement FSM states IDLE, RUN, REQ, DEAD.
REQ-018 IDLE: tick counter held at 0; start=1 -> RUN next cycle.
REQ-019 RUN: tick counter increments each cycle; at count TICK-1 it wraps to 0, applies the pending dir and computes the next head.
REQ-020 Next head: right x+XDIM, left x-XDIM, down y+YDIM, up y-YDIM; arithmetic is done one bit wider than the port, so an underflow shows as a negative result.
REQ-021 On a legal step (0 <= x <= XSCREEN-XDIM and 0 <= y <= YSCREEN-YDIM): prev_* <= old head, head_* <= new head, -> REQ; step_req goes high the cycle after the terminal tick.
REQ-022 REQ: step_req=1 and tick counter frozen; step_ack=1 -> step_req=0 and -> RUN next cycle; key presses are still latched as pending.
REQ-023 step_ack while not in REQ SHALL be ignored.
REQ-024 Illegal step without WRAP_EN: head_* and prev_* unchanged, dead=1, -> DEAD; step_req stays 0.
REQ-025 DEAD is left only by reset; start and keys are ignored there.

Reset
REQ-026 When Resetn=0 at a clock edge, the block SHALL set state IDLE, head_x=X0, head_y=Y0, prev_x=X0, prev_y=Y0, dir=00, pending dir=00, step_req=0, dead=0, and clear tick, debounce and synchronizer registers.
REQ-027 Reset mid-REQ SHALL drop step_req in the same edge, with no further handshake.

Configuration
REQ-028 Macro SNAKE_WRAP_EN: when defined, an illegal step wraps instead of killing: right -> x=0, left -> x=XSCREEN-XDIM, down -> y=0, up -> y=YSCREEN-YDIM; the wrapped step is then handled as a normal step (REQ-021) and dead is tied to 0.
REQ-029 Without SNAKE_WRAP_EN, REQ-024 applies.

Verification (TICK=4, DB_CYC=3)
REQ-030 Reset, start=1, KEY=1111, ack each request one cycle after it appears -> first step_req with head=(49,59), prev=(39,59), dir=00.
REQ-031 Hold KEY[2] low for 3 cycles -> next step gives head_y = previous head_y - 10, dir=10; a 2-cycle glitch on KEY[2] -> no change.
REQ-032 Moving right, press left -> ignored, dir stays 00; press down then left before the next tick -> the step goes down (dir 01), and the left press is applied on the following step.
REQ-033 Withhold step_ack for 20 cycles -> step_req stays high, head/prev stable, no extra step; ack -> next step_req exactly TICK+1 cycles later.
REQ-034 Move right from x=150 -> without macro: dead=1, head=(150,y), no step_req; with SNAKE_WRAP_EN: head_x=0, prev_x=150, dead=0.
REQ-035 Assert Resetn=0 while step_req=1 -> next cycle: step_req=0, state IDLE, head=(39,59).
